// File: rtl/resilient_stage_ctrl_pkg.sv
// resilient_pkg: shared states, default widths and the masked max-wait helper
package resilient_pkg;

    typedef enum logic [2:0] {IDLE, CAPT, CHECK, RECOVER, HAND} state_e;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_ERR_CH    = 2;
    localparam int DEF_WAIT_W    = 5;
    localparam int DEF_MAX_RETRY = 3;
    localparam int DEF_CNT_W     = 16;
    localparam int RETRY_W       = 4;
    localparam int MAX_CH        = 8;
    localparam int MAX_WAIT_W    = 16;
    localparam int WAITS_W       = MAX_CH * MAX_WAIT_W;

    // Callers zero-extend to the widest supported shape; ww is the real field width.
    function automatic logic [MAX_WAIT_W-1:0] max_masked_wait(
        input logic [MAX_CH-1:0]  err,
        input logic [WAITS_W-1:0] waits,
        input int                 ww
    );
        logic [MAX_WAIT_W-1:0] m;
        logic [MAX_WAIT_W-1:0] v;
        m = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            v = MAX_WAIT_W'(waits >> (i * ww)) & MAX_WAIT_W'((1 << ww) - 1);
            if (err[i] && v > m) m = v;
        end
        return m;
    endfunction

endpackage

// File: rtl/resilient_stage_ctrl_recovery_timer.sv
// recovery_timer: selects the longest wait among flagged channels and counts it down
module recovery_timer import resilient_pkg::*; #(
    parameter int ERR_CH = DEF_ERR_CH,
    parameter int WAIT_W = DEF_WAIT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_i,
    input  logic [ERR_CH-1:0]        err_i,
    input  logic [ERR_CH*WAIT_W-1:0] err_wait_i,
    output logic                     expire_o,
    output logic [WAIT_W-1:0]        count_o
);

    logic [MAX_WAIT_W-1:0] max_w;
    logic [WAIT_W-1:0]     load_val;
    logic [WAIT_W-1:0]     count_q, count_d;

    assign max_w    = max_masked_wait(MAX_CH'(err_i), WAITS_W'(err_wait_i), WAIT_W);
    assign load_val = (max_w == '0) ? WAIT_W'(1) : WAIT_W'(max_w);

    // Load on an erroring CHECK, otherwise count down to zero and hold there.
    always_comb count_d = load_i ? load_val : (count_q != '0) ? count_q - WAIT_W'(1) : count_q;

    // Counter register; reset abandons any recovery in progress.
    always_ff @(posedge clk or negedge rst)
        if (!rst) count_q <= '0;
        else      count_q <= count_d;

    assign expire_o = count_q == WAIT_W'(1);
    assign count_o  = count_q;

endmodule

// File: rtl/resilient_stage_ctrl.sv
// resilient_stage_ctrl: resilient bundled-data stage controller; RESILIENT_STAGE_CTRL_STATS_EN enables err_cnt
module resilient_stage_ctrl import resilient_pkg::*; #(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ERR_CH    = DEF_ERR_CH,
    parameter int WAIT_W    = DEF_WAIT_W,
    parameter int MAX_RETRY = DEF_MAX_RETRY,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     Lreq,
    input  logic [WIDTH-1:0]         Ldata,
    output logic                     Lack,
    output logic                     Rreq,
    input  logic                     Rack,
    output logic [WIDTH-1:0]         Rdata,
    input  logic [ERR_CH-1:0]        Err,
    input  logic [ERR_CH*WAIT_W-1:0] err_wait,
    output logic                     sample,
    output logic                     fault,
    output logic [CNT_W-1:0]         err_cnt
);

    state_e               state_q, state_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic                 lack_q, lack_d;
    logic                 rreq_q, rreq_d;
    logic                 fault_q, fault_d;
    logic                 disarmed_q, disarmed_d;
    logic [WIDTH-1:0]     data_q;
    logic                 load;
    logic                 expire;
    logic [WAIT_W-1:0]    rec_cnt;

    recovery_timer #(.ERR_CH(ERR_CH), .WAIT_W(WAIT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .err_i      (Err),
        .err_wait_i (err_wait),
        .expire_o   (expire),
        .count_o    (rec_cnt)
    );

    // Next-state logic: capture, check/retry, recover, then run both handshakes.
    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        lack_d     = lack_q;
        rreq_d     = rreq_q;
        fault_d    = fault_q;
        disarmed_d = disarmed_q;
        load       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!Lreq)            disarmed_d = 1'b0;
                else if (!disarmed_q) state_d    = CAPT;
            end
            CAPT: state_d = CHECK;
            CHECK: begin
                if (|Err && retry_q < RETRY_W'(MAX_RETRY)) begin
                    load    = 1'b1;
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = RECOVER;
                end else begin
                    fault_d = fault_q | (|Err);
                    lack_d  = 1'b1;
                    rreq_d  = 1'b1;
                    retry_d = '0;
                    state_d = HAND;
                end
            end
            RECOVER: if (expire || rec_cnt == '0) state_d = CAPT;
            HAND: begin
                lack_d = lack_q & Lreq;
                rreq_d = rreq_q & ~Rack;
                if (!lack_q && !rreq_q && !Rack) begin
                    state_d    = IDLE;
                    disarmed_d = Lreq;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; reset discards any in-flight token.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            retry_q    <= '0;
            lack_q     <= 1'b0;
            rreq_q     <= 1'b0;
            fault_q    <= 1'b0;
            disarmed_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            retry_q    <= retry_d;
            lack_q     <= lack_d;
            rreq_q     <= rreq_d;
            fault_q    <= fault_d;
            disarmed_q <= disarmed_d;
        end
    end

    // Stage data register, reloaded on every capture including resamples.
    always_ff @(posedge clk or negedge rst)
        if (!rst)                 data_q <= '0;
        else if (state_q == CAPT) data_q <= Ldata;

`ifdef RESILIENT_STAGE_CTRL_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating count of erroring CHECK cycles.
    always_comb cnt_d = (state_q == CHECK && |Err && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

    // Statistics register.
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;

    assign err_cnt = cnt_q;
`else
    assign err_cnt = '0;
`endif

    assign Lack   = lack_q;
    assign Rreq   = rreq_q;
    assign Rdata  = data_q;
    assign sample = state_q == CAPT;
    assign fault  = fault_q;

endmodule

// File: doc/resilient_stage_ctrl.md
# resilient_stage_ctrl

Clocked, parametrised controller for one resilient bundled-data pipeline stage. It runs a four-phase left handshake and a four-phase right handshake, captures the stage data, and checks it against ERR_CH timing-error detector channels. On a detected error it waits a per-channel recovery interval and resamples, retrying up to MAX_RETRY times before flagging a sticky fault. It sits between two pipeline stages and drives the stage capture strobe.

## Interface
- WIDTH, 32, data width.
- ERR_CH, 2, number of error-detector channels (1..8).
- WAIT_W, 5, width of each per-channel recovery-wait field.
- MAX_RETRY, 3, resample attempts allowed per token (1..15).
- CNT_W, 16, width of the error statistics counter.

- clk  in  1  stage clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- Lreq  in  1  left request (four-phase).
- Ldata  in  WIDTH  left data; must be stable while Lreq is high.
- Lack  out  1  left acknowledge.
- Rreq  out  1  right request (four-phase).
- Rack  in  1  right acknowledge.
- Rdata  out  WIDTH  right data (the captured register).
- Err  in  ERR_CH  detector flags; valid only in the CHECK cycle.
- err_wait  in  ERR_CH*WAIT_W  recovery cycles for each channel; channel i is at [i*WAIT_W +: WAIT_W]; quasi-static.
- sample  out  1  capture strobe; high for exactly one cycle per capture.
- fault  out  1  sticky flag: a token was forwarded after retries were exhausted.
- err_cnt  out  CNT_W  saturating count of CHECK cycles that had an error.

## Operation
- States: IDLE, CAPT, CHECK, RECOVER, HAND.
- IDLE, Lreq sampled 1: go to CAPT.
- CAPT:
  - sample=1.
  - Ldata is loaded into the data register at the end of the cycle.
  - Go to CHECK.
- CHECK, Err==0:
  - Lack<=1, Rreq<=1.
  - Go to HAND.
  - Clear the retry count.
- CHECK, Err!=0 and retry<MAX_RETRY:
  - Recovery counter <= the maximum err_wait over the asserted channels; a value of 0 is treated as 1.
  - retry++.
  - Go to RECOVER.
- CHECK, Err!=0 and retry==MAX_RETRY:
  - fault<=1.
  - Forward the token exactly as in the no-error case.
- RECOVER:
  - Decrement the counter each cycle.
  - When it reaches 1, go to CAPT (resample).
  - Lreq is held high by protocol, so Ldata remains valid.
- HAND: the two sub-handshakes run independently.
  - Lack falls the cycle after Lreq is sampled 0.
  - Rreq falls the cycle after Rack is sampled 1.
  - Go to IDLE when Lack=0, Rreq=0 and Rack is sampled 0.
- Err is ignored outside CHECK.
- Rdata holds its value until the next CAPT.
- Lreq still high on return to IDLE is treated as a protocol violation. It is not accepted until Lreq has been sampled low at least once; an internal armed bit enforces this.

## Timing
- Reset values: Lack=0, Rreq=0, sample=0, fault=0, err_cnt=0, Rdata=0, state IDLE, retry=0, disarmed=0.
- No-error latency, counting from the edge that samples Lreq=1:
  - sample is high during cycle 1.
  - Lack and Rreq are high after edge 3.
- An error with wait W adds W+2 cycles per retry: W cycles in RECOVER, plus CAPT and CHECK again.
- err_cnt:
  - Increments once per erroring CHECK cycle.
  - Saturates at 2^CNT_W-1; no wrap.
- Simultaneous Lreq fall and Rack rise: both Lack and Rreq fall on the same edge.
- Reset asserted mid-token:
  - All outputs clear asynchronously.
  - An in-flight token is discarded.
  - After reset, Lreq already high is accepted as a new request.

## Configuration
- RESILIENT_STAGE_CTRL_STATS_EN defined: err_cnt counts as specified.
- Not defined: err_cnt is tied to 0 and the counter logic is omitted. The port still exists and all other behaviour is identical.

## Structure
- Package resilient_pkg holds:
  - the state enum (IDLE, CAPT, CHECK, RECOVER, HAND);
  - the default-width constants;
  - a function returning the maximum masked wait.
- Sub-module recovery_timer (parameters ERR_CH, WAIT_W):
  - inputs: load, Err, err_wait;
  - outputs: expire and the count;
  - performs the max-select and the down-counter.

## Test plan
- Clean token: Lreq=1 with Ldata=0xA5A5_0001 and Err=0 -> sample pulses once; Lack=Rreq=1 three edges after Lreq sampled; Rdata=0xA5A5_0001; Rack handshake returns the block to IDLE.
- Single error, channel 0 with wait 5: Err=01 in the first CHECK -> 5 cycles of RECOVER, a second sample pulse, Rreq 7 cycles later than the clean case; err_cnt=1; fault=0.
- Both channels asserted, waits 5 and 15 -> RECOVER lasts 15 cycles (the maximum).
- Errors on every CHECK with MAX_RETRY=3 -> 4 sample pulses, fault=1, token forwarded, err_cnt=4; fault persists over later clean tokens until rst=0.
- Rack high in the same cycle Lreq falls -> Lack and Rreq drop on the same edge; the next token is accepted.
- rst pulsed low during RECOVER -> all outputs 0 immediately; with Lreq still high after release, a fresh CAPT occurs.
